sound_event_sequencer: RTL and testbench
========================================

// Module: sound_event_sequencer
// PURPOSE
//  Producer side of the game-to-audio event interface. Turns the game logic's raw collision/score
//  levels into one-hot, single-cycle pulses (paddle_hit, wall_hit, score1, score2) for the tone block.
//  Queues concurrent events in arrival order and spaces pulses by a guaranteed gap, so one tone
//  never clobbers another.
// PARAMETERS
//  GAP_CYCLES  250000  idle cycles after each pulse (5 ms at 50 MHz; equals the tone duration)
//  DEPTH       4       event FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1  system clock; single clock domain
//  rst            in   1  synchronous, active-high reset
//  enable         in   1  game running; 0 = flush and ignore events
//  paddle_contact in   1  level from ball logic, high while ball touches a paddle
//  wall_contact   in   1  level, high while ball touches top/bottom wall
//  score1_in      in   1  level/pulse, player 1 scored
//  score2_in      in   1  level/pulse, player 2 scored
//  paddle_hit     out  1  1-cycle pulse to tone block
//  wall_hit       out  1  1-cycle pulse to tone block
//  score1         out  1  1-cycle pulse to tone block
//  score2         out  1  1-cycle pulse to tone block
//  busy           out  1  FSM not IDLE, or FIFO/pending non-empty
//  merge_count    out  8  saturating count of events merged into an already-pending event
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, pending=0, FSM=IDLE, merge_count=0.
//    prev_in <= current inputs, so levels held through reset do not fire.
//  - Edge detect: edge[i] = in[i] & ~prev_in[i]; prev_in is updated every cycle.
//  - Event codes: EVT_PADDLE=0, EVT_WALL=1, EVT_SCORE1=2, EVT_SCORE2=3.
//  - Pending: a 4-bit sticky register; pending[i] <= pending[i] | edge[i].
//    An edge on an already-set bit is a merge: merge_count +1, saturating at 255.
//  - Push: each cycle, if pending!=0 and the FIFO is not full, push the highest-priority pending code
//    and clear that bit. Priority: SCORE1 > SCORE2 > PADDLE > WALL.
//    Same-cycle clear and set of one bit: the set wins, with no merge counted.
//  - FIFO full: pending bits hold. No event is lost except by merge.
//  - FSM:
//      IDLE -> FIRE when the FIFO is non-empty.
//      FIRE: 1 cycle; pop; the matching output is high for exactly this cycle; load gap counter.
//      FIRE -> GAP.
//      GAP: lasts GAP_CYCLES cycles -> IDLE.
//  - Latency: input rises in cycle n -> pending set at n+1 -> FIFO non-empty at n+2
//    -> pulse in cycle n+3 (FSM idle, nothing queued ahead).
//  - Backlog: pulse start-to-start spacing is exactly GAP_CYCLES+2.
//  - Outputs: registered; at most one of the four is high in any cycle (one-hot or zero).
//  - enable=0: synchronous flush.
//    FIFO emptied, pending cleared, FSM -> IDLE, all pulse outputs 0 in the next cycle.
//    Edges in this state are ignored; prev_in still tracks the inputs; merge_count is kept.
//  - Reset mid-GAP or mid-FIRE: same as reset. A pulse in flight ends immediately, no re-fire.
//  - Gap counter width: $clog2(GAP_CYCLES+1); GAP_CYCLES=0 is legal (FIRE->GAP 0 cycles->IDLE).
// STRUCTURE
//  - Shared header pong_sound_defs.vh: EVT_* codes, EVT_W=2.
//    sound.v and this block use the same event ordering.
//  - Sub-module sound_evt_fifo: synchronous FIFO, params WIDTH=EVT_W, DEPTH.
//    Ports: push, pop, din, dout, full, empty; flush input driven by rst|~enable.
//    dout is valid while !empty (first-word fall-through).
//  - Top: edge detect, pending/priority encoder, FSM, gap counter, output register, merge counter.
// TESTING (bench uses GAP_CYCLES=8, DEPTH=4)
//  1. Hold paddle_contact high from reset through 20 cycles
//     -> no pulse. Drop it, raise it at cycle 30 -> paddle_hit high in cycle 33 only.
//  2. Raise wall_contact, score1_in and paddle_contact in the same cycle n
//     -> score1 at n+3, paddle_hit at n+13, wall_hit at n+23. Never two outputs high at once.
//  3. Toggle paddle_contact 3 times while PADDLE is pending (FIFO full via score backlog)
//     -> merge_count=3 and exactly one extra paddle_hit pulse.
//  4. Queue 4 events, then drop enable for 1 cycle during GAP
//     -> outputs 0, busy=0 two cycles later, no further pulses, merge_count unchanged.
//  5. Assert rst during FIRE of score2 -> score2 low the next cycle.
//     After release, no pulse until a new edge.
//  6. 300 random edge bursts vs. a reference model
//     -> pulse sequence matches, spacing >= GAP_CYCLES+2, one-hot invariant holds.

Source files
------------

// File: rtl/sound_event_sequencer_pkg.sv
// Shared event codes and helpers for the game-to-audio event path.
// Event ordering must stay identical to the tone block's decoder.
package sound_event_sequencer_pkg;

    localparam int EVT_W = 2;
    localparam int N_EVT = 4;

    typedef enum logic [EVT_W-1:0] {
        EVT_PADDLE = 2'd0,
        EVT_WALL   = 2'd1,
        EVT_SCORE1 = 2'd2,
        EVT_SCORE2 = 2'd3
    } evt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Scores first so a point is never delayed behind bounce noise
    function automatic evt_e prio_pick(input logic [N_EVT-1:0] p);
        if (p[EVT_SCORE1])      return EVT_SCORE1;
        else if (p[EVT_SCORE2]) return EVT_SCORE2;
        else if (p[EVT_PADDLE]) return EVT_PADDLE;
        else                    return EVT_WALL;
    endfunction

    function automatic logic [N_EVT-1:0] evt_onehot(input evt_e c);
        logic [N_EVT-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sound_event_sequencer_if.sv
// Game-side levels in, tone-block pulses and status out.
interface sound_event_sequencer_if;
    logic       enable;
    logic       paddle_contact;
    logic       wall_contact;
    logic       score1_in;
    logic       score2_in;
    logic       paddle_hit;
    logic       wall_hit;
    logic       score1;
    logic       score2;
    logic       busy;
    logic [7:0] merge_count;

    modport master (
        output enable, paddle_contact, wall_contact, score1_in, score2_in,
        input  paddle_hit, wall_hit, score1, score2, busy, merge_count
    );

    modport slave (
        input  enable, paddle_contact, wall_contact, score1_in, score2_in,
        output paddle_hit, wall_hit, score1, score2, busy, merge_count
    );
endinterface

// File: rtl/sound_event_sequencer_evt_fifo.sv
// Small first-word-fall-through FIFO for queued event codes.
// flush empties it synchronously and overrides push/pop.
module sound_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/sound_event_sequencer.sv
// Turns game contact/score levels into spaced, one-hot tone pulses.
// Edges collect in a sticky pending set, drain by priority into a FIFO, then fire one per gap.
module sound_event_sequencer
    import sound_event_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = 250000,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sound_event_sequencer_if.slave  bus
);
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    logic [N_EVT-1:0] raw_in, prev_in, evt_edge;
    logic [N_EVT-1:0] pending, pending_d, clr, merge_v;
    logic [N_EVT-1:0] pulse_q, pulse_d;
    logic [7:0]       merge_q, merge_d;
    logic [8:0]       merge_sum;
    logic [2:0]       merge_n;
    logic             push, pop, gap_load;
    evt_e             push_code;
    logic [EVT_W-1:0] fifo_dout;
    logic             fifo_full, fifo_empty;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] gap_cnt;

    assign raw_in   = {bus.score2_in, bus.score1_in, bus.wall_contact, bus.paddle_contact};
    assign evt_edge = raw_in & ~prev_in & {N_EVT{bus.enable}};

    always_comb begin
        push      = (|pending) & ~fifo_full & bus.enable;
        push_code = prio_pick(pending);
        clr       = push ? evt_onehot(push_code) : '0;
        // A bit being drained this cycle is re-set, not merged
        merge_v   = evt_edge & pending & ~clr;
        pending_d = (pending & ~clr) | evt_edge;
        merge_n   = 3'($countones(merge_v));
        merge_sum = {1'b0, merge_q} + {6'd0, merge_n};
        merge_d   = merge_sum[8] ? 8'hFF : merge_sum[7:0];
    end

    always_ff @(posedge clk) begin
        prev_in <= raw_in;
        if (rst) begin
            pending <= '0;
            merge_q <= '0;
        end else begin
            pending <= bus.enable ? pending_d : '0;
            merge_q <= merge_d;
        end
    end

    sound_evt_fifo #(.WIDTH(EVT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .flush (rst | ~bus.enable),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_FIRE;
            ST_FIRE: state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (!bus.enable) state_d = ST_IDLE;
    end

    // Pulse register is loaded on the IDLE->FIRE edge so it is high exactly during FIRE
    always_comb begin
        pop      = (state_q == ST_FIRE);
        gap_load = (state_q == ST_FIRE);
        pulse_d  = '0;
        if (state_q == ST_IDLE && !fifo_empty && bus.enable)
            pulse_d = evt_onehot(evt_e'(fifo_dout));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
            gap_cnt <= '0;
        end else begin
            pulse_q <= pulse_d;
            if (gap_load)
                gap_cnt <= GAP_LOAD;
            else if (state_q == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    assign bus.paddle_hit  = pulse_q[EVT_PADDLE];
    assign bus.wall_hit    = pulse_q[EVT_WALL];
    assign bus.score1      = pulse_q[EVT_SCORE1];
    assign bus.score2      = pulse_q[EVT_SCORE2];
    assign bus.merge_count = merge_q;
    assign bus.busy        = (state_q != ST_IDLE) | ~fifo_empty | (|pending);
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed scenarios plus random bursts for sound_event_sequencer (GAP_CYCLES=8, DEPTH=4).
module tb_sound_event_sequencer;
    localparam int GAP = 8;
    localparam int SP  = GAP + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sound_event_sequencer_if bus();

    sound_event_sequencer #(.GAP_CYCLES(GAP), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int onehot_bad = 0;
    int q_cyc[$];
    int q_code[$];
    logic [3:0] mon_o;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: cycle index and code of every output pulse
    always @(negedge clk) begin
        mon_o = {bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit};
        if (mon_o != 4'b0000 && !$isunknown(mon_o)) begin
            q_cyc.push_back(cyc);
            q_code.push_back(mon_o[0] ? 0 : mon_o[1] ? 1 : mon_o[2] ? 2 : 3);
        end
        if ($countones(mon_o) > 1) onehot_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic set_in(input logic [3:0] v);
        bus.paddle_contact = v[0];
        bus.wall_contact   = v[1];
        bus.score1_in      = v[2];
        bus.score2_in      = v[3];
    endtask

    task automatic clr_q();
        q_cyc.delete();
        q_code.delete();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, budget);
        end
    endtask

    task automatic test_reset();
        int n;
        bus.enable = 1'b1;
        set_in(4'b0001);
        rst = 1'b1;
        ticks(3);
        n_cmp++;
        if ({bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b, required 0000", {bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit});
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.merge_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_status: busy=%b merge=%0d, required 0/0", bus.busy, bus.merge_count);
        end
        rst = 1'b0;
        clr_q();
        ticks(20);
        n_cmp++;
        if (q_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL held_level: %0d pulses, required 0", q_cyc.size());
        end
        set_in(4'b0000);
        ticks(9);
        n = cyc;
        set_in(4'b0001);
        ticks(3);
        n_cmp++;
        if (bus.paddle_hit !== 1'b1) begin
            n_bad++;
            $display("FAIL paddle_latency: paddle_hit=%b at n+3, required 1", bus.paddle_hit);
        end
        tick();
        n_cmp++;
        if (bus.paddle_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL paddle_width: paddle_hit=%b at n+4, required 0", bus.paddle_hit);
        end
        wait_idle(30);
        n_cmp++;
        if (q_cyc.size() != 1 || q_cyc[0] != n + 3 || q_code[0] != 0) begin
            n_bad++;
            $display("FAIL paddle_single: %0d pulses first at %0d, required 1 at %0d", q_cyc.size(),
                     (q_cyc.size() > 0) ? q_cyc[0] : -1, n + 3);
        end
    endtask

    task automatic test_concurrent();
        int n;
        int exp_c[3];
        int exp_k[3];
        set_in(4'b0000);
        ticks(2);
        clr_q();
        n = cyc;
        set_in(4'b0111);
        exp_c = '{n + 3, n + 13, n + 23};
        exp_k = '{2, 0, 1};
        ticks(25);
        wait_idle(40);
        n_cmp++;
        if (q_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL concurrent_count: %0d pulses, required 3", q_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (q_cyc[i] != exp_c[i] || q_code[i] != exp_k[i]) begin
                    n_bad++;
                    $display("FAIL concurrent_%0d: code %0d at %0d, required code %0d at %0d",
                             i, q_code[i], q_cyc[i], exp_k[i], exp_c[i]);
                end
            end
        end
        n_cmp++;
        if (onehot_bad != 0) begin
            n_bad++;
            $display("FAIL onehot_concurrent: %0d violations, required 0", onehot_bad);
        end
        set_in(4'b0000);
        tick();
    endtask

    task automatic test_merge();
        int c;
        int m0;
        int exp_c[6];
        int exp_k[6];
        logic [3:0] seq [12];
        seq = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b0001,
                4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
        set_in(4'b0000);
        ticks(2);
        m0 = int'(bus.merge_count);
        clr_q();
        c = cyc;
        for (int i = 0; i < 12; i++) begin
            set_in(seq[i]);
            tick();
        end
        n_cmp++;
        if (int'(bus.merge_count) != m0 + 3) begin
            n_bad++;
            $display("FAIL merge_count: got %0d, required %0d", bus.merge_count, m0 + 3);
        end
        wait_idle(100);
        exp_c = '{c + 3, c + 13, c + 23, c + 33, c + 43, c + 53};
        exp_k = '{2, 3, 2, 3, 2, 0};
        n_cmp++;
        if (q_cyc.size() != 6) begin
            n_bad++;
            $display("FAIL merge_pulses: %0d pulses, required 6", q_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (q_cyc[i] != exp_c[i] || q_code[i] != exp_k[i]) begin
                    n_bad++;
                    $display("FAIL merge_seq_%0d: code %0d at %0d, required code %0d at %0d",
                             i, q_code[i], q_cyc[i], exp_k[i], exp_c[i]);
                end
            end
        end
        set_in(4'b0000);
        tick();
    endtask

    task automatic test_flush();
        int n;
        int m0;
        set_in(4'b0000);
        ticks(2);
        m0 = int'(bus.merge_count);
        clr_q();
        n = cyc;
        set_in(4'b1111);
        ticks(6);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pre_busy: busy=%b during gap, required 1", bus.busy);
        end
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        n_cmp++;
        if ({bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit} !== 4'b0000) begin
            n_bad++;
            $display("FAIL flush_outputs: got %b, required 0000", {bus.score2, bus.score1, bus.wall_hit, bus.paddle_hit});
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_busy: busy=%b, required 0", bus.busy);
        end
        ticks(40);
        n_cmp++;
        if (q_cyc.size() != 1 || q_cyc[0] != n + 3 || q_code[0] != 2) begin
            n_bad++;
            $display("FAIL flush_pulses: %0d pulses, required only score1 at %0d", q_cyc.size(), n + 3);
        end
        n_cmp++;
        if (int'(bus.merge_count) != m0) begin
            n_bad++;
            $display("FAIL flush_merge: got %0d, required %0d", bus.merge_count, m0);
        end
        set_in(4'b0000);
        tick();
    endtask

    task automatic test_reset_fire();
        int n;
        set_in(4'b0000);
        ticks(2);
        clr_q();
        n = cyc;
        set_in(4'b1000);
        ticks(3);
        n_cmp++;
        if (bus.score2 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_fire_pre: score2=%b in FIRE, required 1", bus.score2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.score2 !== 1'b0 || bus.merge_count !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_fire_cut: score2=%b merge=%0d, required 0/0", bus.score2, bus.merge_count);
        end
        ticks(20);
        n_cmp++;
        if (q_cyc.size() != 1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_fire_refire: %0d pulses busy=%b, required 1 pulse busy=0", q_cyc.size(), bus.busy);
        end
        set_in(4'b0000);
        tick();
        set_in(4'b1000);
        ticks(3);
        n_cmp++;
        if (bus.score2 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_fire_new_edge: score2=%b, required 1", bus.score2);
        end
        wait_idle(30);
        set_in(4'b0000);
        tick();
    endtask

    task automatic test_random();
        int n;
        int k;
        logic [3:0] mask;
        int exp_k[$];
        int order[4];
        order = '{2, 3, 0, 1};
        for (int b = 0; b < 300; b++) begin
            mask = 4'($urandom_range(1, 15));
            ticks($urandom_range(0, 3));
            clr_q();
            n = cyc;
            set_in(mask);
            tick();
            set_in(4'b0000);
            wait_idle(60);
            exp_k.delete();
            for (int j = 0; j < 4; j++)
                if (mask[order[j]]) exp_k.push_back(order[j]);
            n_cmp++;
            if (q_cyc.size() != exp_k.size()) begin
                n_bad++;
                $display("FAIL rand_%0d_count: mask %b gave %0d pulses, required %0d", b, mask, q_cyc.size(), exp_k.size());
            end else begin
                for (int j = 0; j < exp_k.size(); j++) begin
                    k = n + 3 + j * SP;
                    n_cmp++;
                    if (q_cyc[j] != k || q_code[j] != exp_k[j]) begin
                        n_bad++;
                        $display("FAIL rand_%0d_%0d: code %0d at %0d, required code %0d at %0d",
                                 b, j, q_code[j], q_cyc[j], exp_k[j], k);
                    end
                end
            end
        end
        n_cmp++;
        if (onehot_bad != 0) begin
            n_bad++;
            $display("FAIL onehot_random: %0d violations, required 0", onehot_bad);
        end
    endtask

    initial begin
        bus.enable = 1'b1;
        set_in(4'b0000);
        test_reset();
        test_concurrent();
        test_merge();
        test_flush();
        test_reset_fire();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
